ps2_key_decoder: RTL and testbench

//   Upstream input stage of the game top level. Receives PS/2 keyboard frames on keyclk/keyinput and

---
 rtl/ps2_key_decoder.sv | 232 +++++++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_decoder
// Brief    : PS/2 set-2 keyboard receiver. Handles the E0/F0 prefixes and
//            produces key events plus a held-key vector.
//            Optional macro PS2_PARITY_CHECK_EN enables the odd-parity check.
// Revision : 1.0  initial release
// ============================================================================
module ps2_key_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        keyclk,
    input  logic        keyinput,
    output logic        key_valid,
    output logic [7:0]  key_code,
    output logic        key_ext,
    output logic        key_break,
    output logic [13:0] held,
    output logic        frame_err
);

    localparam int FC_W = $clog2(FILTER_LEN + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FC_W-1:0] FILT_LAST = FC_W'(FILTER_LEN - 1);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    logic            clk_s1, clk_s2, dat_s1, dat_s2;
    logic [FC_W-1:0] filt_cnt;
    logic            filt, filt_d;
    logic            fall_edge;

    state_t          state, state_nxt;
    logic [7:0]      shift, shift_nxt;
    logic [2:0]      bit_cnt, bit_cnt_nxt;
    logic [TO_W-1:0] to_cnt, to_nxt;
    logic            byte_rdy, byte_rdy_nxt;
    logic            err_nxt;
    logic            ext_flag, brk_flag;
    logic            par_bad;
`ifdef PS2_PARITY_CHECK_EN
    logic            par_bit, par_nxt;
`endif

    // Bus idles high, so synchronizers and filter come out of reset at 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= keyclk;
            clk_s2 <= clk_s1;
            dat_s1 <= keyinput;
            dat_s2 <= dat_s1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_cnt <= '0;
            filt     <= 1'b1;
            filt_d   <= 1'b1;
        end else begin
            filt_d <= filt;
            if (clk_s2 != filt) begin
                if (filt_cnt == FILT_LAST) begin
                    filt     <= clk_s2;
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + 1'b1;
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    assign fall_edge = filt_d & ~filt;

`ifdef PS2_PARITY_CHECK_EN
    assign par_bad = ~(^{shift, par_bit});
`else
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift     <= '0;
            bit_cnt   <= '0;
            to_cnt    <= '0;
            byte_rdy  <= 1'b0;
            frame_err <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            par_bit   <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            shift     <= shift_nxt;
            bit_cnt   <= bit_cnt_nxt;
            to_cnt    <= to_nxt;
            byte_rdy  <= byte_rdy_nxt;
            frame_err <= err_nxt;
`ifdef PS2_PARITY_CHECK_EN
            par_bit   <= par_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt    = state;
        shift_nxt    = shift;
        bit_cnt_nxt  = bit_cnt;
        byte_rdy_nxt = 1'b0;
        err_nxt      = 1'b0;
        to_nxt       = to_cnt + 1'b1;
`ifdef PS2_PARITY_CHECK_EN
        par_nxt      = par_bit;
`endif
        if (state == IDLE || fall_edge) begin
            to_nxt = '0;
        end
        if (fall_edge) begin
            case (state)
                IDLE: begin
                    if (!dat_s2) begin
                        state_nxt   = DATA;
                        bit_cnt_nxt = '0;
                    end
                end
                DATA: begin
                    shift_nxt   = {dat_s2, shift[7:1]};
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_nxt = PARITY;
                    end
                end
                PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                    par_nxt   = dat_s2;
`endif
                    state_nxt = STOP;
                end
                default: begin
                    state_nxt = IDLE;
                    if (!dat_s2 || par_bad) begin
                        err_nxt = 1'b1;
                    end else begin
                        byte_rdy_nxt = 1'b1;
                    end
                end
            endcase
        end else if (state != IDLE && to_cnt == TO_LAST) begin
            // Stalled mid-frame: drop the partial byte.
            state_nxt = IDLE;
            shift_nxt = '0;
            err_nxt   = 1'b1;
            to_nxt    = '0;
        end
    end

    function automatic logic [13:0] key_mask(input logic ext, input logic [7:0] code);
        key_mask = '0;
        case ({ext, code})
            9'h175:  key_mask[0]  = 1'b1;
            9'h172:  key_mask[1]  = 1'b1;
            9'h16B:  key_mask[2]  = 1'b1;
            9'h174:  key_mask[3]  = 1'b1;
            9'h05A:  key_mask[4]  = 1'b1;
            9'h01D:  key_mask[5]  = 1'b1;
            9'h01C:  key_mask[6]  = 1'b1;
            9'h01B:  key_mask[7]  = 1'b1;
            9'h023:  key_mask[8]  = 1'b1;
            9'h03B:  key_mask[9]  = 1'b1;
            9'h042:  key_mask[10] = 1'b1;
            9'h04B:  key_mask[11] = 1'b1;
            9'h043:  key_mask[12] = 1'b1;
            9'h02D:  key_mask[13] = 1'b1;
            default: key_mask     = '0;
        endcase
    endfunction

    // The received byte stays in the shift register until the next frame starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_valid <= 1'b0;
            key_code  <= '0;
            key_ext   <= 1'b0;
            key_break <= 1'b0;
            held      <= '0;
            ext_flag  <= 1'b0;
            brk_flag  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (frame_err) begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end else if (byte_rdy) begin
                if (shift == 8'hE0) begin
                    ext_flag <= 1'b1;
                end else if (shift == 8'hF0) begin
                    brk_flag <= 1'b1;
                end else begin
                    key_valid <= 1'b1;
                    key_code  <= shift;
                    key_ext   <= ext_flag;
                    key_break <= brk_flag;
                    ext_flag  <= 1'b0;
                    brk_flag  <= 1'b0;
                    if (brk_flag) begin
                        held <= held & ~key_mask(ext_flag, shift);
                    end else begin
                        held <= held | key_mask(ext_flag, shift);
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_key_decoder
// Brief    : Self-checking bench for ps2_key_decoder with a scan-code model.
// Revision : 1.0  initial release
// ============================================================================
module tb_ps2_key_decoder;

    localparam int FL   = 8;
    localparam int TO   = 1000;
    localparam int HALF = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        keyclk = 1'b1;
    logic        keyinput = 1'b1;
    logic        key_valid;
    logic [7:0]  key_code;
    logic        key_ext;
    logic        key_break;
    logic [13:0] held;
    logic        frame_err;

    ps2_key_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .keyclk    (keyclk),
        .keyinput  (keyinput),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_ext   (key_ext),
        .key_break (key_break),
        .held      (held),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_valid = 0;
    int          n_err   = 0;
    int          v_cyc   = 0;
    logic [7:0]  v_code  = '0;
    logic        v_ext   = 1'b0;
    logic        v_brk   = 1'b0;
    logic [13:0] v_held  = '0;

    always @(negedge clk) begin
        if (key_valid) begin
            n_valid = n_valid + 1;
            v_cyc   = cyc;
            v_code  = key_code;
            v_ext   = key_ext;
            v_brk   = key_break;
            v_held  = held;
        end
        if (frame_err) n_err = n_err + 1;
    end

    int checks = 0;
    int fails  = 0;
    int stop_cyc = 0;

    logic        m_ext  = 1'b0;
    logic        m_brk  = 1'b0;
    logic [13:0] m_held = '0;
    logic [8:0]  key_map [14] = '{9'h175, 9'h172, 9'h16B, 9'h174, 9'h05A, 9'h01D, 9'h01C,
                                  9'h01B, 9'h023, 9'h03B, 9'h042, 9'h04B, 9'h043, 9'h02D};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame bits LSB first: start, 8 data, odd parity, stop.
    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop, input int nbits);
        logic [10:0] f;
        f = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            keyinput = f[i];
            repeat (HALF / 2) @(negedge clk);
            keyclk = 1'b0;
            if (i == 10) stop_cyc = cyc;
            repeat (HALF) @(negedge clk);
            keyclk = 1'b1;
            repeat (HALF / 2) @(negedge clk);
        end
        keyinput = 1'b1;
    endtask

    task automatic expect_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        int v0, e0;
        bit drop;
        v0 = n_valid;
        e0 = n_err;
        send_frame(b, bad_par, bad_stop, 11);
        repeat (30) @(negedge clk);
`ifdef PS2_PARITY_CHECK_EN
        drop = bad_par | bad_stop;
`else
        drop = bad_stop;
`endif
        if (drop) begin
            m_ext = 1'b0;
            m_brk = 1'b0;
            check("err_pulse", n_err - e0, 1);
            check("no_event_on_err", n_valid - v0, 0);
        end else if (b == 8'hE0 || b == 8'hF0) begin
            if (b == 8'hE0) m_ext = 1'b1;
            else            m_brk = 1'b1;
            check("prefix_no_event", n_valid - v0, 0);
            check("prefix_no_err", n_err - e0, 0);
        end else begin
            for (int i = 0; i < 14; i++)
                if (key_map[i] == {m_ext, b}) m_held[i] = ~m_brk;
            check("event_count", n_valid - v0, 1);
            check("event_err", n_err - e0, 0);
            check("event_fields", {23'd0, v_ext, v_brk, v_code}, {23'd0, m_ext, m_brk, b});
            check("event_latency", v_cyc - stop_cyc, FL + 4);
            check("held_at_event", {18'd0, v_held}, {18'd0, m_held});
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
        check("held", {18'd0, held}, {18'd0, m_held});
    endtask

    initial begin
        int v0, e0;
        logic [7:0] code;
        logic       ext, rel;

        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {key_valid, key_code, key_ext, key_break, held, frame_err}, '0);

        expect_byte(8'h1D, 0, 0);
        check("w_held", {31'd0, held[5]}, 1);
        expect_byte(8'hF0, 0, 0);
        expect_byte(8'h1D, 0, 0);
        expect_byte(8'hE0, 0, 0);
        expect_byte(8'h75, 0, 0);
        check("up_held", {31'd0, held[0]}, 1);
        expect_byte(8'hE0, 0, 0);
        expect_byte(8'hF0, 0, 0);
        expect_byte(8'h75, 0, 0);
        expect_byte(8'h75, 0, 0);
        expect_byte(8'h5A, 1, 0);
        expect_byte(8'hE0, 0, 0);
        expect_byte(8'h6B, 0, 1);
        expect_byte(8'h74, 0, 0);

        v0 = n_valid;
        e0 = n_err;
        send_frame(8'h55, 0, 0, 6);
        repeat (TO / 2) @(negedge clk);
        check("no_early_timeout", n_err - e0, 0);
        repeat (TO) @(negedge clk);
        check("timeout_err", n_err - e0, 1);
        check("timeout_no_event", n_valid - v0, 0);
        expect_byte(8'h2D, 0, 0);
        check("r_held", {31'd0, held[13]}, 1);

        v0 = n_valid;
        e0 = n_err;
        @(negedge clk);
        keyclk = 1'b0;
        repeat (FL - 2) @(negedge clk);
        keyclk = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_no_err", n_err - e0, 0);
        check("glitch_no_event", n_valid - v0, 0);
        expect_byte(8'h1C, 0, 0);

        for (int n = 0; n < 20; n++) begin
            if ($urandom_range(0, 3) != 0) begin
                int k;
                k    = $urandom_range(0, 13);
                code = key_map[k][7:0];
                ext  = key_map[k][8];
            end else begin
                code = 8'($urandom);
                if (code == 8'hE0 || code == 8'hF0) code = 8'h12;
                ext = 1'($urandom);
            end
            rel = 1'($urandom);
            if (ext) expect_byte(8'hE0, 0, 0);
            if (rel) expect_byte(8'hF0, 0, 0);
            expect_byte(code, 0, 0);
        end

        v0 = n_valid;
        e0 = n_err;
        send_frame(8'h3B, 0, 0, 5);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        m_held = '0;
        m_ext  = 1'b0;
        m_brk  = 1'b0;
        check("midreset_no_err", n_err - e0, 0);
        check("midreset_no_event", n_valid - v0, 0);
        check("midreset_outputs", {key_code, key_ext, key_break, held}, '0);
        expect_byte(8'h3B, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
